fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage RV32 pipeline. Owns the fetch PC, issues single-outstanding requests to instruction memory over a valid/ready request and valid response interface, and drives the IF/ID pipeline register consumed by decode. Handles stall, IF/ID flush and branch/jump redirect from the hazard unit and execute stage, including discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded on flush/empty
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, always word-aligned
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid, one per accepted request, in order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- PCTargetE  in  32  redirect target from execute
- Branch_or_Jump_taken  in  1  redirect strobe, one cycle
- if_id_stall  in  1  hold IF/ID and PC
- if_id_flush  in  1  load bubble into IF/ID, PC unaffected
- instrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCPlus4D  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction

## Operation
- Registers: PCF (32), state, hold buffer (32 data + its PC), IF/ID (instrD, PCD, PCPlus4D, validD).
- States: REQ, WAIT, HOLD, DROP.
- REQ: imem_req_valid=1, addr=PCF. Accepted (valid&ready) -> WAIT. Not accepted -> stay.
- WAIT: await rsp. rsp & !stall -> load IF/ID {rsp_data, PCF, PCF+4, valid=1}, PCF<=PCF+4; same cycle imem_req_valid=1 at PCF+4 (combinational rsp->req path); accepted -> WAIT, else -> REQ. rsp & stall -> capture into hold buffer -> HOLD.
- HOLD: no request. When stall drops -> load IF/ID from buffer, PCF<=PCF+4 -> REQ.
- DROP: in-flight response is stale; on rsp discard it -> REQ. No request issued.
- Redirect (Branch_or_Jump_taken=1) has priority over stall and flush: PCF<=PCTargetE & ~32'h3; IF/ID<=bubble; imem_req_valid forced 0 that cycle. From REQ/HOLD -> REQ (hold buffer discarded). From WAIT: rsp same cycle -> discard, REQ; else -> DROP. From DROP: rsp same cycle -> REQ; else stay DROP with new PCF.
- if_id_flush without redirect: IF/ID<=bubble; a response arriving that cycle is still consumed (PCF advances) and discarded — flush wins over load.
- No instruction available, not stalled, not flushed: IF/ID<=bubble.
- Stall without redirect: IF/ID and PCF hold; flush overrides stall on IF/ID.
- Bubble: instrD=NOP_INSTR, PCD=0, PCPlus4D=0, validD=0.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset (async): PCF=RESET_PC, state=REQ, IF/ID=bubble, hold buffer=0; imem_req_valid=0 while reset asserted, 1 in first cycle after deassert.
- Zero-wait memory (ready=1, rsp next cycle): request at cycle N, instrD valid after edge ending cycle N+1; sustained 1 instr/cycle.
- Redirect in cycle N: first request to target in cycle N+1 (from REQ/HOLD or WAIT-with-rsp), else one cycle after stale rsp.
- Reset mid-transaction: state returns to REQ; memory must also be reset (no stale-response tracking across reset).

## Structure
- Shared riscv_pkg: NOP_INSTR constant, fetch state enum (REQ/WAIT/HOLD/DROP), XLEN=32.
- One sub-module: if_id_reg — IF/ID register with load, stall, flush (bubble) controls; FSM and PC in fetch_stage.

## Test plan
- Reset, ready=1, 1-cycle rsp, imem returns 0x00500093 at 0x0 -> reqs 0x0,0x4,0x8 on consecutive cycles; instrD=0x00500093, PCD=0, PCPlus4D=4, validD=1.
- Stall 3 cycles during WAIT with rsp arriving -> HOLD; IF/ID unchanged for 3 cycles, no request issued; buffered instr appears one cycle after stall drops, PCF advances by 4 once.
- Redirect to 0x100 while WAIT, rsp delayed 2 cycles -> DROP; stale rsp discarded, validD=0, next req addr=0x100.
- Redirect to 0x203 simultaneous with stall -> PCF=0x200, IF/ID bubble, stall ignored that cycle.
- if_id_flush with rsp same cycle -> instrD=0x00000013, validD=0, next req at PCF+4.
- PCF=0xFFFFFFFC fetched -> next request addr 0x00000000, PCPlus4D=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath width, bubble encoding and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, stall holds, load captures a fetched instruction.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr        <= NOP_INSTR;
      pc           <= '0;
      pc_plus4_out <= '0;
      valid        <= 1'b0;
    end else if (flush) begin
      instr        <= NOP_INSTR;
      pc           <= '0;
      pc_plus4_out <= '0;
      valid        <= 1'b0;
    end else if (!stall) begin
      // Nothing to deliver this cycle still means decode sees a bubble.
      instr        <= load ? instr_in : NOP_INSTR;
      pc           <= load ? pc_in : '0;
      pc_plus4_out <= load ? pc_plus4(pc_in) : '0;
      valid        <= load;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC and request FSM with single outstanding request, stall buffering,
// redirect handling and stale-response dropping; feeds the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            Branch_or_Jump_taken,
  input  logic            if_id_stall,
  input  logic            if_id_flush,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD
);

  fetch_state_e    state;
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] hold_data;
  logic [XLEN-1:0] hold_pc;

  logic            rsp_live;
  logic            req_fire;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  assign rsp_live = (state == WAIT) && imem_rsp_valid;

  // A live response frees the slot, so the next request goes out in the same cycle.
  assign imem_req_valid = !reset && !Branch_or_Jump_taken &&
                          ((state == REQ) || (rsp_live && !if_id_stall));
  assign imem_req_addr  = (state == WAIT) ? pc_plus4(pcf) : pcf;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign load       = (rsp_live || (state == HOLD)) && !if_id_stall;
  assign load_instr = (state == HOLD) ? hold_data : imem_rsp_data;
  assign load_pc    = (state == HOLD) ? hold_pc : pcf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= REQ;
      pcf       <= RESET_PC;
      hold_data <= '0;
      hold_pc   <= '0;
    end else if (Branch_or_Jump_taken) begin
      pcf <= PCTargetE & ~32'h3;
      // An outstanding request that has not yet answered must be drained before refetching.
      if ((state == WAIT || state == DROP) && !imem_rsp_valid) begin
        state <= DROP;
      end else begin
        state <= REQ;
      end
    end else begin
      unique case (state)
        REQ: begin
          if (req_fire) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (if_id_stall) begin
              hold_data <= imem_rsp_data;
              hold_pc   <= pcf;
              state     <= HOLD;
            end else begin
              pcf   <= pc_plus4(pcf);
              state <= req_fire ? WAIT : REQ;
            end
          end
        end
        HOLD: begin
          if (!if_id_stall) begin
            pcf   <= pc_plus4(pcf);
            state <= REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) state <= REQ;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .stall        (if_id_stall),
    .flush        (Branch_or_Jump_taken || if_id_flush),
    .instr_in     (load_instr),
    .pc_in        (load_pc),
    .instr        (instrD),
    .pc           (PCD),
    .pc_plus4_out (PCPlus4D),
    .valid        (validD)
  );

endmodule
